// File: rtl/half_subtractor_nand_pkg.sv
// Shared constants for the NAND-only half subtractor bank.
package half_subtractor_nand_pkg;

    // Default lane count when the parent does not override WIDTH.
    localparam int unsigned WidthDefault = 1;

    // Per-lane reset values; replicated across WIDTH by the top level.
    localparam logic DiffRst   = 1'b0;
    localparam logic BorrowRst = 1'b0;
    localparam logic ValidRst  = 1'b0;

endpackage

// File: rtl/nand2_cell.sv
// Single-bit 2-input NAND; the only logic primitive used by the subtractor lanes.
module nand2_cell (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a & b);

endmodule

// File: rtl/half_subtractor_nand.sv
// Registered bank of WIDTH independent half subtractors (a - b), each lane built
// from five NAND2 cells. Results appear one clock after an in_valid edge.
module half_subtractor_nand
    import half_subtractor_nand_pkg::*;
#(
    parameter int unsigned WIDTH = WidthDefault
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic [WIDTH-1:0] borrow,
    output logic             out_valid
);

    // Internal NAND network nodes, one bit per lane.
    logic [WIDTH-1:0] n1;
    logic [WIDTH-1:0] n2;
    logic [WIDTH-1:0] n3;
    logic [WIDTH-1:0] d_comb;
    logic [WIDTH-1:0] br_comb;

    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_d;
    logic [WIDTH-1:0] borrow_q;
    logic [WIDTH-1:0] borrow_d;
    logic             valid_q;
    logic             valid_d;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_lane
        // n1 = ~(a&b); n2/n3 split it into the classic 4-NAND XOR.
        nand2_cell u_n1 (.a(a[i]),  .b(b[i]),  .y(n1[i]));
        nand2_cell u_n2 (.a(a[i]),  .b(n1[i]), .y(n2[i]));
        nand2_cell u_n3 (.a(b[i]),  .b(n1[i]), .y(n3[i]));
        nand2_cell u_d  (.a(n2[i]), .b(n3[i]), .y(d_comb[i]));
        // n3 = ~(b & ~(a&b)) = ~(~a & b); a NAND used as inverter recovers the borrow.
        nand2_cell u_br (.a(n3[i]), .b(n3[i]), .y(br_comb[i]));
    end

    // Next state: load fresh lane results on in_valid, otherwise hold data and drop valid.
    always_comb begin
        diff_d   = diff_q;
        borrow_d = borrow_q;
        valid_d  = in_valid;
        if (in_valid) begin
            diff_d   = d_comb;
            borrow_d = br_comb;
        end
    end

    // Output and valid registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q   <= {WIDTH{DiffRst}};
            borrow_q <= {WIDTH{BorrowRst}};
            valid_q  <= ValidRst;
        end else begin
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            valid_q  <= valid_d;
        end
    end

    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_half_subtractor_nand.sv
// Self-checking bench: WIDTH=1 and WIDTH=4 instances against an arithmetic model.
module tb_half_subtractor_nand;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;

    logic [0:0] diff1, borrow1;
    logic [3:0] diff4, borrow4;
    logic       ov1, ov4;

    int n_checks = 0;
    int n_errors = 0;

    half_subtractor_nand #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1),
        .diff(diff1), .borrow(borrow1), .out_valid(ov1)
    );

    half_subtractor_nand #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4), .b(b4),
        .diff(diff4), .borrow(borrow4), .out_valid(ov4)
    );

    always #5 clk = ~clk;

    // Reference model: per-lane subtraction a-b; difference is the low bit,
    // borrow is set when the minuend is smaller than the subtrahend.
    logic [3:0] m_diff4 = '0, m_borrow4 = '0;
    logic [0:0] m_diff1 = '0, m_borrow1 = '0;
    logic       m_valid = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_diff1 = '0; m_borrow1 = '0; m_diff4 = '0; m_borrow4 = '0; m_valid = 1'b0;
        end else begin
            if (in_valid) begin
                int ai, bi;
                ai = int'(a1[0]); bi = int'(b1[0]);
                m_diff1[0]   = ((ai - bi) % 2) != 0;
                m_borrow1[0] = ai < bi;
                for (int i = 0; i < 4; i++) begin
                    ai = int'(a4[i]); bi = int'(b4[i]);
                    m_diff4[i]   = ((ai - bi) % 2) != 0;
                    m_borrow4[i] = ai < bi;
                end
            end
            m_valid = in_valid;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        check("cmp_valid1", 32'(ov1), 32'(m_valid));
        check("cmp_valid4", 32'(ov4), 32'(m_valid));
        check("cmp_diff1", 32'(diff1), 32'(m_diff1));
        check("cmp_borrow1", 32'(borrow1), 32'(m_borrow1));
        check("cmp_diff4", 32'(diff4), 32'(m_diff4));
        check("cmp_borrow4", 32'(borrow4), 32'(m_borrow4));
    end

    task automatic check_zero(input string name);
        check({name, "_diff1"}, 32'(diff1), 32'd0);
        check({name, "_borrow1"}, 32'(borrow1), 32'd0);
        check({name, "_valid1"}, 32'(ov1), 32'd0);
        check({name, "_diff4"}, 32'(diff4), 32'd0);
        check({name, "_borrow4"}, 32'(borrow4), 32'd0);
        check({name, "_valid4"}, 32'(ov4), 32'd0);
    endtask

    logic [3:0] diff_tab;
    logic [3:0] borrow_tab;

    initial begin
        // Reset held with active-looking inputs: outputs must stay cleared.
        #1 rst_n = 1'b0;
        in_valid = 1'b1; a1 = 1'b1; b1 = 1'b1; a4 = 4'hf; b4 = 4'hf;
        repeat (3) begin
            @(posedge clk); #1;
            check_zero("reset_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;

        // Exhaustive single-lane truth table, index = {a,b}.
        diff_tab   = 4'b0110;
        borrow_tab = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1; a1[0] = k[1]; b1[0] = k[0];
            @(posedge clk); #1;
            check("tt_diff", 32'(diff1), 32'(diff_tab[k]));
            check("tt_borrow", 32'(borrow1), 32'(borrow_tab[k]));
            check("tt_valid", 32'(ov1), 32'd1);
        end

        // Hold: capture 0-1, then idle with 1,1 presented.
        @(negedge clk);
        in_valid = 1'b1; a1 = 1'b0; b1 = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a1 = 1'b1; b1 = 1'b1;
        @(posedge clk); #1;
        check("hold_diff", 32'(diff1), 32'd1);
        check("hold_borrow", 32'(borrow1), 32'd1);
        check("hold_valid", 32'(ov1), 32'd0);

        // Four-lane vector.
        @(negedge clk);
        in_valid = 1'b1; a4 = 4'b0011; b4 = 4'b0101;
        @(posedge clk); #1;
        check("w4_diff", 32'(diff4), 32'h6);
        check("w4_borrow", 32'(borrow4), 32'h4);
        check("w4_valid", 32'(ov4), 32'd1);

        // Random traffic with random valid gaps.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            a1 = 1'($urandom); b1 = 1'($urandom);
            a4 = 4'($urandom); b4 = 4'($urandom);
        end

        // Asynchronous reset between edges right after capturing 0-1.
        @(negedge clk);
        in_valid = 1'b1; a1 = 1'b0; b1 = 1'b1; a4 = 4'b0000; b4 = 4'b1111;
        @(posedge clk); #1;
        check("pre_rst_borrow1", 32'(borrow1), 32'd1);
        check("pre_rst_borrow4", 32'(borrow4), 32'hf);
        #1 rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(posedge clk); #1;
        check_zero("async_rst_edge");
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("post_rst_valid", 32'(ov1), 32'd0);
        check("post_rst_diff4", 32'(diff4), 32'd0);

        // First capture after release.
        @(negedge clk);
        in_valid = 1'b1; a4 = 4'b1010; b4 = 4'b0110;
        @(posedge clk); #1;
        check("post_rst_cap_diff4", 32'(diff4), 32'hc);
        check("post_rst_cap_borrow4", 32'(borrow4), 32'h4);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
